divisor_secuencial: RTL and testbench
=====================================

// Module: divisor_secuencial
// PURPOSE
//  Sequential unsigned restoring divider; responder end of the inicie/termino handshake
//  that stimulus and control blocks drive. Latches dividendo/divisor on accepted start,
//  computes one quotient bit per reloj cycle, returns cociente/residuo, raises termino.
//  Sits between any master issuing divide requests and downstream consumers of results.
// PARAMETERS
//  DD_LEN  31  MSB index of dividendo and cociente (width DD_LEN+1)
//  DV_LEN  15  MSB index of divisor and residuo (width DV_LEN+1)
// PORTS
//  reloj      in   1         clock, all state on rising edge
//  reset      in   1         asynchronous, active-low reset
//  inicie     in   1         start request, level, 4-phase with termino
//  dividendo  in   DD_LEN+1  unsigned dividend, sampled only on accept edge
//  divisor    in   DV_LEN+1  unsigned divisor, sampled only on accept edge
//  cociente   out  DD_LEN+1  quotient, registered, held until next completion
//  residuo    out  DV_LEN+1  remainder, registered, held until next completion
//  termino    out  1         1 = idle/result valid; 0 = busy or awaiting inicie low
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, termino=1, cociente=0, residuo=0, counter=0.
//   Reset mid-operation aborts the divide; no partial result ever reaches the outputs.
//  FSM: IDLE -> CALC -> (IDLE | ESPERA).
//   IDLE   termino=1. Rising edge with inicie=1: accept; latch operands, rem=0,
//          cnt=DD_LEN+1, next CALC. inicie=0: stay.
//   CALC   termino=0. Each edge: {rem,q} shifted left 1; if rem_shift>=divisor then
//          rem=rem_shift-divisor, q[0]=1 else q[0]=0; cnt-1. On the edge where cnt
//          reaches 0: cociente<=q, residuo<=rem; next IDLE if inicie=0, else ESPERA.
//          inicie changes during CALC are ignored.
//   ESPERA termino=0; next IDLE when inicie=0. Prevents a level-held inicie retriggering.
//  Latency: accept at edge k; termino=0 after edge k; results and termino=1 after
//   edge k+DD_LEN+1 (inicie low by then). Fixed, independent of operand values.
//  Widths: partial remainder is DV_LEN+2 bits (one guard bit) so compare/subtract
//   never overflows; residuo < divisor always when divisor!=0.
//  divisor==0: detected at accept; full fixed latency still runs; result forced to
//   cociente=all ones, residuo=0.
//  Operand inputs may change at any time outside the accept edge without effect.
//  termino is a registered state decode; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared include divisor_defs.vh: `DdLen, `DvLen, `QLen defaults and the FSM state
//   encodings (IDLE=2'd0, CALC=2'd1, ESPERA=2'd2); used by divider and probador.
//  One natural sub-module: divisor_paso -- combinational single restoring step
//   (rem_in, dividend bit, divisor -> rem_out, q_bit). Top holds FSM, counter, registers.
// TESTING
//  1 Reset pulse low 3 units mid-run -> termino=1, cociente=0, residuo=0 at once.
//  2 dividendo=32'h352, divisor=16'h3, inicie=1 -> after 32 cycles cociente=0x11B, residuo=1.
//  3 dividendo=32'd1024, divisor=16'h20 -> cociente=32, residuo=0; termino low exactly 32 cycles.
//  4 dividendo=32'hFFFFFFFF, divisor=1 -> cociente=0xFFFFFFFF, residuo=0; 5/7 -> cociente 0, residuo 5.
//  5 dividendo=32'h1234, divisor=0 -> cociente=0xFFFFFFFF, residuo=0, same 32-cycle latency.
//  6 inicie held 1 through completion -> results valid, termino stays 0 (ESPERA),
//    termino=1 one edge after inicie=0; no second divide started.

Source files
------------

// File: rtl/divisor_secuencial_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// The FSM encoding is fixed so external checkers can decode the debug state port.
package divisor_secuencial_pkg;

  localparam int DD_LEN_DEF = 31;
  localparam int DV_LEN_DEF = 15;
  localparam int Q_LEN_DEF  = DD_LEN_DEF + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    ESPERA = 2'd2
  } estado_t;

  // Counter must be able to hold DD_LEN+1 (one step per quotient bit).
  function automatic int cnt_width(input int dd_len);
    return $clog2(dd_len + 2);
  endfunction

endpackage

// File: rtl/divisor_secuencial_if.sv
// Request/result bundle between a divide master and the divider.
// Handshake is 4-phase: master raises inicie while termino=1; the divider accepts on that
// edge and drops termino; when termino returns to 1 the result is valid and the master must
// have released inicie (a held inicie parks the divider in ESPERA until it drops).
interface divisor_secuencial_if #(
  parameter int DD_LEN = 31,
  parameter int DV_LEN = 15
);

  logic              inicie;
  logic [DD_LEN:0]   dividendo;
  logic [DV_LEN:0]   divisor;
  logic [DD_LEN:0]   cociente;
  logic [DV_LEN:0]   residuo;
  logic              termino;

  modport master (
    output inicie, dividendo, divisor,
    input  cociente, residuo, termino
  );

  modport slave (
    input  inicie, dividendo, divisor,
    output cociente, residuo, termino
  );

endinterface

// File: rtl/divisor_secuencial_paso.sv
// One combinational restoring step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and emit the quotient bit.
module divisor_secuencial_paso #(
  parameter int DV_LEN = 15
) (
  input  logic [DV_LEN:0] rem_in,
  input  logic            bit_in,
  input  logic [DV_LEN:0] divisor,
  output logic [DV_LEN:0] rem_out,
  output logic            q_bit
);

  // One guard bit above the remainder so the compare never overflows.
  logic [DV_LEN+1:0] rem_shift;
  logic              cabe;

  always_comb begin
    rem_shift = {rem_in, bit_in};
    cabe      = (rem_shift >= {1'b0, divisor});
    q_bit     = cabe;
    // When the divisor fits the true difference is below 2^(DV_LEN+1), so the low bits suffice.
    rem_out   = cabe ? (rem_shift[DV_LEN:0] - divisor) : rem_shift[DV_LEN:0];
  end

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential unsigned restoring divider: one quotient bit per clock, fixed latency,
// results registered and held until the next completion.
module divisor_secuencial
  import divisor_secuencial_pkg::*;
#(
  parameter int DD_LEN = DD_LEN_DEF,
  parameter int DV_LEN = DV_LEN_DEF
) (
  input  logic                 reloj,
  input  logic                 reset,
  divisor_secuencial_if.slave  bus,
  output estado_t              estado
);

  localparam int CNT_W = cnt_width(DD_LEN);
  localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(DD_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_UNO = CNT_W'(1);

  estado_t           estado_q, estado_d;
  logic              acepta, ultimo;

  logic [DD_LEN:0]   q_r;
  logic [DV_LEN:0]   rem_r;
  logic [DV_LEN:0]   div_r;
  logic              div_cero_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DD_LEN:0]   cociente_r;
  logic [DV_LEN:0]   residuo_r;

  logic [DV_LEN:0]   rem_sig;
  logic              q_bit;
  logic [DD_LEN:0]   q_sig;

  divisor_secuencial_paso #(
    .DV_LEN (DV_LEN)
  ) u_paso (
    .rem_in  (rem_r),
    .bit_in  (q_r[DD_LEN]),
    .divisor (div_r),
    .rem_out (rem_sig),
    .q_bit   (q_bit)
  );

  assign q_sig = {q_r[DD_LEN-1:0], q_bit};

  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      estado_q <= IDLE;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    acepta   = 1'b0;
    ultimo   = 1'b0;
    case (estado_q)
      IDLE: begin
        if (bus.inicie) begin
          acepta   = 1'b1;
          estado_d = CALC;
        end
      end
      CALC: begin
        // inicie is only looked at on the final step, to decide between IDLE and ESPERA.
        if (cnt_r == CNT_UNO) begin
          ultimo   = 1'b1;
          estado_d = bus.inicie ? ESPERA : IDLE;
        end
      end
      ESPERA: begin
        if (!bus.inicie) begin
          estado_d = IDLE;
        end
      end
      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  // Working registers: operands are captured only on the accept edge.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      q_r        <= '0;
      rem_r      <= '0;
      div_r      <= '0;
      div_cero_r <= 1'b0;
      cnt_r      <= '0;
    end else if (acepta) begin
      q_r        <= bus.dividendo;
      rem_r      <= '0;
      div_r      <= bus.divisor;
      div_cero_r <= (bus.divisor == '0);
      cnt_r      <= CNT_INI;
    end else if (estado_q == CALC) begin
      q_r        <= q_sig;
      rem_r      <= rem_sig;
      cnt_r      <= cnt_r - CNT_UNO;
    end
  end

  // Result registers change only on the final step, so an aborted divide never leaks out.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      cociente_r <= '0;
      residuo_r  <= '0;
    end else if (ultimo) begin
      cociente_r <= div_cero_r ? '1 : q_sig;
      residuo_r  <= div_cero_r ? '0 : rem_sig;
    end
  end

  assign bus.cociente = cociente_r;
  assign bus.residuo  = residuo_r;
  assign bus.termino  = (estado_q == IDLE);
  assign estado       = estado_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Bench for divisor_secuencial: directed corner cases plus random divides, checked
// against plain-arithmetic expectations through an expected-result queue.
module tb_divisor_secuencial;
  import divisor_secuencial_pkg::*;

  localparam int DD_LEN = 31;
  localparam int DV_LEN = 15;
  localparam int W      = (DD_LEN + 1) + (DV_LEN + 1);
  localparam int LAT    = DD_LEN + 1;
  localparam int LIMITE = 100;

  logic    reloj;
  logic    reset;
  estado_t estado;

  divisor_secuencial_if #(.DD_LEN(DD_LEN), .DV_LEN(DV_LEN)) bus ();

  divisor_secuencial #(
    .DD_LEN (DD_LEN),
    .DV_LEN (DV_LEN)
  ) dut (
    .reloj  (reloj),
    .reset  (reset),
    .bus    (bus),
    .estado (estado)
  );

  // ---------------- clock / reset ----------------
  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: ordinary integer division; divide-by-zero gives all ones / zero.
  function automatic logic [W-1:0] modelo(input logic [DD_LEN:0] dd, input logic [DV_LEN:0] dv);
    logic [DD_LEN:0] q;
    logic [DV_LEN:0] r;
    if (dv == 0) begin
      q = '1;
      r = '0;
    end else begin
      q = dd / {{(DD_LEN-DV_LEN){1'b0}}, dv};
      r = DV_LEN'(dd % {{(DD_LEN-DV_LEN){1'b0}}, dv});
    end
    return {q, r};
  endfunction

  // ---------------- driver ----------------
  task automatic dividir(input logic [DD_LEN:0] dd, input logic [DV_LEN:0] dv,
                         input bit mantener, input string tag);
    int cyc;
    logic [W-1:0] exp;
    logic [DD_LEN:0] q_ant;
    logic [DV_LEN:0] r_ant;
    @(negedge reloj);
    bus.dividendo = dd;
    bus.divisor   = dv;
    bus.inicie    = 1'b1;
    exp_q.push_back(modelo(dd, dv));
    @(posedge reloj); #1;
    chk({tag, "_termino_acepta"}, 64'(bus.termino), 64'd0);
    cyc = 0;
    do begin
      @(negedge reloj);
      bus.dividendo = $urandom;
      bus.divisor   = DV_LEN'($urandom);
      if (!mantener)
        bus.inicie = (cyc < LAT - 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge reloj); #1;
      cyc++;
    end while (bus.termino !== 1'b1 && cyc < (mantener ? LAT : LIMITE));
    exp = exp_q.pop_front();
    if (!mantener)
      chk({tag, "_latencia"}, 64'(cyc), 64'(LAT));
    chk({tag, "_cociente"}, 64'(bus.cociente), 64'(exp[W-1 -: DD_LEN+1]));
    chk({tag, "_residuo"},  64'(bus.residuo),  64'(exp[DV_LEN:0]));
    if (mantener) begin
      chk({tag, "_termino_espera"}, 64'(bus.termino), 64'd0);
      chk({tag, "_estado_espera"},  64'(estado), 64'(ESPERA));
      repeat (3) @(posedge reloj);
      #1;
      chk({tag, "_sigue_espera"}, 64'(bus.termino), 64'd0);
      q_ant = bus.cociente;
      r_ant = bus.residuo;
      @(negedge reloj);
      bus.inicie = 1'b0;
      @(posedge reloj); #1;
      chk({tag, "_termino_libera"}, 64'(bus.termino), 64'd1);
      repeat (2) @(posedge reloj);
      #1;
      chk({tag, "_sin_redisparo"}, 64'(bus.termino), 64'd1);
      chk({tag, "_cociente_retenido"}, 64'(bus.cociente), 64'(q_ant));
      chk({tag, "_residuo_retenido"},  64'(bus.residuo),  64'(r_ant));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DV_LEN:0] dv;
    int sel;
    reset         = 1'b0;
    bus.inicie    = 1'b0;
    bus.dividendo = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge reloj);
    reset = 1'b1;
    @(posedge reloj); #1;
    chk("reset_termino",  64'(bus.termino),  64'd1);
    chk("reset_cociente", 64'(bus.cociente), 64'd0);
    chk("reset_residuo",  64'(bus.residuo),  64'd0);
    chk("reset_estado",   64'(estado),       64'(IDLE));

    dividir(32'h352, 16'h3, 1'b0, "d352_3");
    dividir(32'd1024, 16'h20, 1'b0, "d1024_32");
    dividir(32'hFFFF_FFFF, 16'h1, 1'b0, "dmax_1");
    dividir(32'd5, 16'd7, 1'b0, "d5_7");
    dividir(32'h1234, 16'h0, 1'b0, "div_cero");
    dividir(32'd100, 16'd9, 1'b1, "mantenido");

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0)      dv = '0;
      else if (sel <= 2) dv = DV_LEN'($urandom_range(1, 15));
      else               dv = DV_LEN'($urandom);
      dividir($urandom, dv, (sel == 7), "aleatorio");
    end

    // Reset pulse in the middle of a divide: outputs clear immediately, nothing resumes.
    @(negedge reloj);
    bus.dividendo = 32'hDEAD_BEEF;
    bus.divisor   = 16'h0013;
    bus.inicie    = 1'b1;
    @(negedge reloj);
    bus.inicie = 1'b0;
    repeat (10) @(posedge reloj);
    #2;
    reset = 1'b0;
    #1;
    chk("reset_async_termino",  64'(bus.termino),  64'd1);
    chk("reset_async_cociente", 64'(bus.cociente), 64'd0);
    chk("reset_async_residuo",  64'(bus.residuo),  64'd0);
    #2;
    reset = 1'b1;
    repeat (LAT + 2) @(posedge reloj);
    #1;
    chk("post_reset_termino",  64'(bus.termino),  64'd1);
    chk("post_reset_cociente", 64'(bus.cociente), 64'd0);

    dividir(32'd1000, 16'd33, 1'b0, "tras_reset");

    chk("cola_vacia", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
